bin2bcd_seg_fmt: RTL and testbench

- Sequential binary-to-BCD formatter between the I2C ADC reader (rd_data/rd_data_vld) and the 8-digit seg display driver (seg_val[31:0]).
- Replaces combinational divide/modulo with a double-dabble (shift-add-3) converter: one bit per clock, valid/ready input handshake.
- Output is the 8-nibble display word with leading-zero blanking.

---
 rtl/seg_pkg.sv | 9 +
 rtl/bcd_adj3.sv | 7 +
 rtl/bin2bcd_seg_fmt.sv | 105 ++++++++++
 tb/tb_bin2bcd_seg_fmt.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the binary-to-BCD display formatter and the seg display driver.
package seg_pkg;
  localparam logic [3:0] BLANK_CODE  = 4'd10;
  localparam logic [3:0] MINUS_CODE  = 4'd11;
  localparam logic [3:0] PREFIX_CODE = 4'd15;
  localparam int         MAX_DATA_W  = 26;

  typedef enum logic [1:0] {IDLE, SHIFT, BLANK, DONE} state_e;
endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 before the next shift.
module bcd_adj3 (
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);
  assign q_o = (d_i >= 4'd5) ? 4'(d_i + 4'd3) : d_i;
endmodule

// File: rtl/bin2bcd_seg_fmt.sv
// Sequential shift-add-3 binary-to-BCD converter producing the 8-digit display word
// with optional leading-zero blanking; one input bit per clock.
module bin2bcd_seg_fmt
  import seg_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NDIG       = 8,
  parameter int LEAD_BLANK = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic [31:0]       seg_val,
  output logic              out_vld,
  output logic              busy
);
  localparam int CNT_W = 5;

  if (DATA_W < 1 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
    $error("bin2bcd_seg_fmt: DATA_W=%0d outside 1..%0d", DATA_W, MAX_DATA_W);
  end
  if (NDIG != 8) begin : g_bad_ndig
    $error("bin2bcd_seg_fmt: NDIG must be 8, got %0d", NDIG);
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [31:0]       bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       seg_q, seg_d;

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_adj3 u_adj (
      .d_i (bcd_q[4*g +: 4]),
      .q_o (bcd_adj[4*g +: 4])
    );
  end

  // Nibble 0 is never blanked so a zero value still shows a single "0".
  function automatic logic [31:0] blank_lead(input logic [31:0] bcd);
    logic seen;
    blank_lead = bcd;
    seen       = 1'b0;
    for (int k = NDIG - 1; k >= 1; k--) begin
      if (bcd[4*k +: 4] != 4'd0) seen = 1'b1;
      if (!seen && LEAD_BLANK != 0) blank_lead[4*k +: 4] = BLANK_CODE;
    end
  endfunction

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    case (state_q)
      IDLE: begin
        if (in_vld) begin
          shreg_d = in_data;
          bcd_d   = '0;
          cnt_d   = CNT_W'(DATA_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d   = {bcd_adj[30:0], shreg_q[DATA_W-1]};
        shreg_d = shreg_q << 1;
        if (cnt_q == '0) state_d = BLANK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      BLANK: begin
        seg_d   = blank_lead(bcd_q);
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and display registers: cleared by reset so an aborted conversion leaves no trace.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seg_q   <= {8{BLANK_CODE}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
    end
  end

  // Working datapath registers: always reloaded on accept, so no reset needed.
  always_ff @(posedge sys_clk) begin
    shreg_q <= shreg_d;
    bcd_q   <= bcd_d;
  end

  assign in_rdy  = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign out_vld = (state_q == DONE);
  assign seg_val = seg_q;
endmodule

// File: tb/tb_bin2bcd_seg_fmt.sv
// Directed bench for bin2bcd_seg_fmt: default build, LEAD_BLANK=0 build and DATA_W=26 build.
module tb_bin2bcd_seg_fmt;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  in_data = '0, in_data_nb = '0;
  logic [25:0] in_data_w = '0;
  logic        in_vld = 1'b0, in_vld_nb = 1'b0, in_vld_w = 1'b0;
  logic        in_rdy, in_rdy_nb, in_rdy_w;
  logic [31:0] seg_val, seg_val_nb, seg_val_w;
  logic        out_vld, out_vld_nb, out_vld_w;
  logic        busy, busy_nb, busy_w;
  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  bin2bcd_seg_fmt #(.DATA_W(8), .NDIG(8), .LEAD_BLANK(1)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data), .in_vld(in_vld),
    .in_rdy(in_rdy), .seg_val(seg_val), .out_vld(out_vld), .busy(busy));

  bin2bcd_seg_fmt #(.DATA_W(8), .NDIG(8), .LEAD_BLANK(0)) dut_nb (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data_nb), .in_vld(in_vld_nb),
    .in_rdy(in_rdy_nb), .seg_val(seg_val_nb), .out_vld(out_vld_nb), .busy(busy_nb));

  bin2bcd_seg_fmt #(.DATA_W(26), .NDIG(8), .LEAD_BLANK(1)) dut_w (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data_w), .in_vld(in_vld_w),
    .in_rdy(in_rdy_w), .seg_val(seg_val_w), .out_vld(out_vld_w), .busy(busy_w));

  // Present one sample for one cycle; lat = rising edges after the accept edge until out_vld.
  task automatic run_main(input logic [7:0] v, output logic [31:0] seg, output int lat);
    @(negedge sys_clk); in_data = v; in_vld = 1'b1;
    @(posedge sys_clk); #1 in_vld = 1'b0;
    lat = -1; seg = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(posedge sys_clk); #1;
      if (out_vld) begin lat = i; seg = seg_val; break; end
    end
  endtask

  task automatic run_nb(input logic [7:0] v, output logic [31:0] seg, output int lat);
    @(negedge sys_clk); in_data_nb = v; in_vld_nb = 1'b1;
    @(posedge sys_clk); #1 in_vld_nb = 1'b0;
    lat = -1; seg = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(posedge sys_clk); #1;
      if (out_vld_nb) begin lat = i; seg = seg_val_nb; break; end
    end
  endtask

  task automatic run_w26(input logic [25:0] v, output logic [31:0] seg, output int lat);
    @(negedge sys_clk); in_data_w = v; in_vld_w = 1'b1;
    @(posedge sys_clk); #1 in_vld_w = 1'b0;
    lat = -1; seg = 'x;
    for (int i = 1; i <= 60; i++) begin
      @(posedge sys_clk); #1;
      if (out_vld_w) begin lat = i; seg = seg_val_w; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    checks++; if (seg_val !== 32'hAAAA_AAAA) begin errors++; $display("FAIL reset_seg: got %h want aaaaaaaa", seg_val); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (seg_val_nb !== 32'hAAAA_AAAA) begin errors++; $display("FAIL reset_seg_nb: got %h want aaaaaaaa", seg_val_nb); end
  endtask

  // Accept at edge E0; out_vld is high after E9, i.e. the 10th cycle counting the cycle in_vld was presented.
  task automatic test_zero();
    logic [31:0] seg; int lat;
    run_main(8'd0, seg, lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL zero_latency: got %0d edges want 9", lat); end
    checks++; if (seg !== 32'hAAAA_AAA0) begin errors++; $display("FAIL zero_seg: got %h want aaaaaaa0", seg); end
    @(posedge sys_clk); #1;
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL zero_pulse_width: got %b want 0", out_vld); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL zero_back_idle: got %b want 1", in_rdy); end
  endtask

  task automatic test_values();
    logic [7:0]  vin[4]   = '{8'd7, 8'd42, 8'd255, 8'd100};
    logic [31:0] exp_b[4] = '{32'hAAAA_AAA7, 32'hAAAA_AA42, 32'hAAAA_A255, 32'hAAAA_A100};
    logic [31:0] exp_n[4] = '{32'h0000_0007, 32'h0000_0042, 32'h0000_0255, 32'h0000_0100};
    logic [31:0] seg; int lat;
    for (int i = 0; i < 4; i++) begin
      run_main(vin[i], seg, lat);
      checks++; if (seg !== exp_b[i]) begin errors++; $display("FAIL blank_val_%0d: got %h want %h", vin[i], seg, exp_b[i]); end
      @(posedge sys_clk);
      run_nb(vin[i], seg, lat);
      checks++; if (seg !== exp_n[i]) begin errors++; $display("FAIL noblank_val_%0d: got %h want %h", vin[i], seg, exp_n[i]); end
      @(posedge sys_clk);
    end
    run_nb(8'd0, seg, lat);
    checks++; if (seg !== 32'h0000_0000) begin errors++; $display("FAIL noblank_zero: got %h want 00000000", seg); end
    @(posedge sys_clk);
  endtask

  // in_data = k+1 ahead of edge Ek with in_vld held: accepts at E0, E11, E22 take 1, 12, 23.
  task automatic test_back_to_back();
    logic [31:0] outs[$];
    int rdy_bad = 0;
    for (int k = 0; k <= 32; k++) begin
      @(negedge sys_clk);
      in_data = 8'(k + 1); in_vld = 1'b1;
      if (in_rdy !== ((k == 0) || (k == 11) || (k == 22))) rdy_bad++;
      @(posedge sys_clk); #1;
      if (out_vld) outs.push_back(seg_val);
    end
    @(negedge sys_clk); in_vld = 1'b0;
    checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL b2b_in_rdy: got %0d wrong cycles want 0", rdy_bad); end
    checks++; if (outs.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d outputs want 3", outs.size()); end
    if (outs.size() == 3) begin
      checks++; if (outs[0] !== 32'hAAAA_AAA1) begin errors++; $display("FAIL b2b_out0: got %h want aaaaaaa1", outs[0]); end
      checks++; if (outs[1] !== 32'hAAAA_AA12) begin errors++; $display("FAIL b2b_out1: got %h want aaaaaa12", outs[1]); end
      checks++; if (outs[2] !== 32'hAAAA_AA23) begin errors++; $display("FAIL b2b_out2: got %h want aaaaaa23", outs[2]); end
    end
    @(posedge sys_clk); #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL b2b_final_idle: got %b want 1", in_rdy); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] seg; int lat; int spurious = 0;
    @(negedge sys_clk); in_data = 8'd200; in_vld = 1'b1;
    @(posedge sys_clk); #1 in_vld = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    sys_rst_n = 1'b0;
    #1;
    checks++; if (seg_val !== 32'hAAAA_AAAA) begin errors++; $display("FAIL midrst_seg: got %h want aaaaaaaa", seg_val); end
    checks++; if (busy !== 1'b0 || out_vld !== 1'b0 || in_rdy !== 1'b1) begin
      errors++; $display("FAIL midrst_ctrl: got busy=%b out_vld=%b in_rdy=%b want 0 0 1", busy, out_vld, in_rdy);
    end
    @(negedge sys_clk); @(negedge sys_clk); sys_rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge sys_clk); #1;
      if (out_vld) spurious++;
    end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL midrst_no_out_vld: got %0d pulses want 0", spurious); end
    run_main(8'd9, seg, lat);
    checks++; if (seg !== 32'hAAAA_AAA9) begin errors++; $display("FAIL midrst_next: got %h want aaaaaaa9", seg); end
    @(posedge sys_clk);
  endtask

  task automatic test_wide();
    logic [31:0] seg; int lat;
    run_w26(26'h3FF_FFFF, seg, lat);
    checks++; if (lat !== 27) begin errors++; $display("FAIL w26_latency: got %0d edges want 27", lat); end
    checks++; if (seg !== 32'h6710_8863) begin errors++; $display("FAIL w26_max: got %h want 67108863", seg); end
    @(posedge sys_clk);
    run_w26(26'd1234567, seg, lat);
    checks++; if (seg !== 32'hA123_4567) begin errors++; $display("FAIL w26_1234567: got %h want a1234567", seg); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
